// File: rtl/spi_arbiter.sv
// spi_arbiter
// Shares one SPI controller between two requesters. A requester is granted
// the controller for a whole transaction of 1..16 bytes; its chip select is
// held low from SETUP through HOLD and its configuration word is frozen at
// grant time. Simultaneous requests are served round-robin.
// All outputs are registered; reset is synchronous and active-low.

module spi_arbiter #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req,
    input  logic [10:0] i_cfg0,
    input  logic [10:0] i_cfg1,
    input  logic [3:0]  i_len0,
    input  logic [3:0]  i_len1,
    input  logic [7:0]  i_tx0,
    input  logic [7:0]  i_tx1,
    input  logic [1:0]  i_tx_valid,
    output logic [1:0]  o_tx_ready,
    output logic [7:0]  o_rx,
    output logic [1:0]  o_rx_valid,
    output logic [1:0]  o_done,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_cs_n,
    output logic [10:0] o_spi_config,
    output logic [7:0]  o_spi_tx,
    output logic        o_spi_tx_valid,
    input  logic [7:0]  i_spi_rx,
    input  logic        i_spi_rx_valid,
    input  logic        i_spi_ready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        FETCH   = 3'd2,
        SEND    = 3'd3,
        WAIT_RX = 3'd4,
        HOLD    = 3'd5,
        RELEASE = 3'd6
    } state_t;

    // Terminal values of the cycle timer in SETUP and HOLD.
    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);

    // One-hot vector for a requester index.
    function automatic logic [1:0] onehot(input logic idx);
        if (idx) begin
            onehot = 2'b10;
        end else begin
            onehot = 2'b01;
        end
    endfunction

    state_t      state_r;
    logic        ptr_r;          // requester favoured on a tie
    logic        owner_r;        // requester currently holding the bus
    logic [4:0]  cnt_r;          // bytes still to be received
    logic [3:0]  timer_r;        // SETUP / HOLD cycle counter
    logic        got_r;          // byte received, waiting for controller ready

    logic [1:0]  cs_n_r;
    logic [1:0]  gnt_r;
    logic [1:0]  tx_ready_r;
    logic [1:0]  rx_valid_r;
    logic [1:0]  done_r;
    logic [7:0]  rx_r;
    logic [7:0]  spi_tx_r;
    logic        spi_tx_valid_r;
    logic [10:0] spi_config_r;

    logic        sel_s;
    logic [3:0]  sel_raw_len_s;
    logic [4:0]  sel_len_s;
    logic [10:0] sel_cfg_s;
    logic        own_tx_valid_s;
    logic [7:0]  own_tx_s;

    // Pick the requester to grant: the favoured one on a tie, else whoever asks.
    always_comb begin
        sel_s = 1'b0;
        if (i_req == 2'b11) begin
            sel_s = ptr_r;
        end else if (i_req[1]) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Configuration and byte count of the selected requester; length 0 means 16.
    always_comb begin
        sel_cfg_s     = 11'd0;
        sel_raw_len_s = 4'd0;
        sel_len_s     = 5'd0;
        if (sel_s) begin
            sel_cfg_s     = i_cfg1;
            sel_raw_len_s = i_len1;
        end else begin
            sel_cfg_s     = i_cfg0;
            sel_raw_len_s = i_len0;
        end
        if (sel_raw_len_s == 4'd0) begin
            sel_len_s = 5'd16;
        end else begin
            sel_len_s = {1'b0, sel_raw_len_s};
        end
    end

    // Transmit byte and valid of the current owner only; the other side is ignored.
    always_comb begin
        own_tx_valid_s = 1'b0;
        own_tx_s       = 8'd0;
        if (owner_r) begin
            own_tx_valid_s = i_tx_valid[1];
            own_tx_s       = i_tx1;
        end else begin
            own_tx_valid_s = i_tx_valid[0];
            own_tx_s       = i_tx0;
        end
    end

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r        <= IDLE;
            ptr_r          <= 1'b0;
            owner_r        <= 1'b0;
            cnt_r          <= 5'd0;
            timer_r        <= 4'd0;
            got_r          <= 1'b0;
            cs_n_r         <= 2'b11;
            gnt_r          <= 2'b00;
            tx_ready_r     <= 2'b00;
            rx_valid_r     <= 2'b00;
            done_r         <= 2'b00;
            rx_r           <= 8'd0;
            spi_tx_r       <= 8'd0;
            spi_tx_valid_r <= 1'b0;
            spi_config_r   <= 11'd0;
        end else begin
            rx_valid_r <= 2'b00;
            done_r     <= 2'b00;
            case (state_r)
                IDLE: begin
                    if ((i_req != 2'b00) && i_spi_ready) begin
                        owner_r      <= sel_s;
                        gnt_r        <= onehot(sel_s);
                        cs_n_r       <= ~onehot(sel_s);
                        spi_config_r <= sel_cfg_s;
                        cnt_r        <= sel_len_s;
                        timer_r      <= 4'd0;
                        got_r        <= 1'b0;
                        state_r      <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    if (timer_r == SETUP_LAST) begin
                        timer_r    <= 4'd0;
                        tx_ready_r <= onehot(owner_r);
                        state_r    <= FETCH;
                    end else begin
                        timer_r <= timer_r + 4'd1;
                    end
                end
                FETCH: begin
                    if (own_tx_valid_s) begin
                        spi_tx_r       <= own_tx_s;
                        spi_tx_valid_r <= 1'b1;
                        tx_ready_r     <= 2'b00;
                        state_r        <= SEND;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                SEND: begin
                    // The controller synchronises valid, so keep it up until it goes busy.
                    if (!i_spi_ready) begin
                        spi_tx_valid_r <= 1'b0;
                        got_r          <= 1'b0;
                        state_r        <= WAIT_RX;
                    end else begin
                        state_r <= SEND;
                    end
                end
                WAIT_RX: begin
                    if (!got_r) begin
                        if (i_spi_rx_valid) begin
                            rx_r       <= i_spi_rx;
                            rx_valid_r <= onehot(owner_r);
                            cnt_r      <= cnt_r - 5'd1;
                            if (cnt_r == 5'd1) begin
                                timer_r <= 4'd0;
                                state_r <= HOLD;
                            end else if (i_spi_ready) begin
                                tx_ready_r <= onehot(owner_r);
                                state_r    <= FETCH;
                            end else begin
                                got_r <= 1'b1;
                            end
                        end else begin
                            state_r <= WAIT_RX;
                        end
                    end else if (i_spi_ready) begin
                        got_r      <= 1'b0;
                        tx_ready_r <= onehot(owner_r);
                        state_r    <= FETCH;
                    end else begin
                        state_r <= WAIT_RX;
                    end
                end
                HOLD: begin
                    if (timer_r == HOLD_LAST) begin
                        timer_r <= 4'd0;
                        cs_n_r  <= 2'b11;
                        gnt_r   <= 2'b00;
                        done_r  <= onehot(owner_r);
                        ptr_r   <= ~owner_r;
                        state_r <= RELEASE;
                    end else begin
                        timer_r <= timer_r + 4'd1;
                    end
                end
                RELEASE: begin
                    // Chip selects stay high here and through IDLE before the next grant.
                    state_r <= IDLE;
                end
                default: begin
                    state_r        <= IDLE;
                    cs_n_r         <= 2'b11;
                    gnt_r          <= 2'b00;
                    tx_ready_r     <= 2'b00;
                    spi_tx_valid_r <= 1'b0;
                    got_r          <= 1'b0;
                    timer_r        <= 4'd0;
                end
            endcase
        end
    end

    assign o_tx_ready     = tx_ready_r;
    assign o_rx           = rx_r;
    assign o_rx_valid     = rx_valid_r;
    assign o_done         = done_r;
    assign o_gnt          = gnt_r;
    assign o_cs_n         = cs_n_r;
    assign o_spi_config   = spi_config_r;
    assign o_spi_tx       = spi_tx_r;
    assign o_spi_tx_valid = spi_tx_valid_r;

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter CS_SETUP, default 2: i_clk cycles from chip-select assertion to first byte handoff (1..15).
REQ-002 Parameter CS_HOLD, default 2: i_clk cycles from last received byte to chip-select release (1..15).
REQ-003 i_clk  in  1  clock; all logic rising-edge.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_req  in  2  per-requester transaction request, level; held until o_done[n].
REQ-006 i_cfg0, i_cfg1  in  11 each  SPI controller configuration word per requester.
REQ-007 i_len0, i_len1  in  4 each  transaction byte count; 0 encodes 16.
REQ-008 i_tx0, i_tx1  in  8 each  next transmit byte per requester.
REQ-009 i_tx_valid  in  2  per-requester transmit-byte valid.
REQ-010 o_tx_ready  out  2  per-requester transmit-byte ready; byte consumed when valid&ready.
REQ-011 o_rx  out  8  received byte, shared.
REQ-012 o_rx_valid  out  2  one-hot 1-cycle pulse, owner of o_rx.
REQ-013 o_done  out  2  one-hot 1-cycle pulse at transaction end.
REQ-014 o_gnt  out  2  one-hot current owner, 0 in IDLE.
REQ-015 o_cs_n  out  2  per-requester chip select, active-low.
REQ-016 o_spi_config  out  11; o_spi_tx  out  8; o_spi_tx_valid  out  1  to SPI controller.
REQ-017 i_spi_rx  in  8; i_spi_rx_valid  in  1; i_spi_ready  in  1  from SPI controller.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, FETCH, SEND, WAIT_RX, HOLD, RELEASE.
REQ-019 IDLE: if any i_req and i_spi_ready=1, grant one requester, latch its cfg and len, go SETUP; else stay.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; pointer after reset favours requester 0.
REQ-021 o_gnt, o_cs_n[owner]=0 and o_spi_config=latched cfg SHALL be driven from the cycle after grant through HOLD; config SHALL not change mid-transaction.
REQ-022 SETUP: count CS_SETUP cycles, then FETCH.
REQ-023 FETCH: o_tx_ready[owner]=1; on i_tx_valid[owner] latch byte into o_spi_tx, go SEND; no timeout, waits indefinitely.
REQ-024 SEND: hold o_spi_tx_valid=1 and o_spi_tx stable until i_spi_ready=0 observed, then deassert valid, go WAIT_RX (valid is held because controller input is synchronized over 2 cycles).
REQ-025 WAIT_RX: on i_spi_rx_valid, o_rx<=i_spi_rx, pulse o_rx_valid[owner] next cycle, decrement remaining count; if count reaches 0 go HOLD, else FETCH once i_spi_ready=1.
REQ-026 HOLD: count CS_HOLD cycles with cs still low, then RELEASE.
REQ-027 RELEASE: o_cs_n=2'b11, o_gnt=0, pulse o_done[owner] for one cycle, update round-robin pointer, go IDLE; minimum one full cycle of cs high between transactions.
REQ-028 Byte counter SHALL be 5 bits; len 0 loaded as 16; exactly len bytes per transaction.
REQ-029 Deassertion of i_req[owner] mid-transaction SHALL be ignored; transaction completes.
REQ-030 i_tx_valid/i_req of non-owner SHALL have no effect; o_tx_ready, o_rx_valid, o_done for non-owner SHALL stay 0.
REQ-031 i_spi_rx_valid outside WAIT_RX SHALL be ignored.

Reset
REQ-032 While i_rst_n=0 at a rising edge: state IDLE, pointer favours 0, o_cs_n=2'b11, o_gnt=0, o_tx_ready=0, o_rx_valid=0, o_done=0, o_spi_tx_valid=0, o_spi_tx=0, o_rx=0, o_spi_config=0, counters 0.
REQ-033 Reset asserted mid-transaction SHALL abort immediately to reset values; no o_done pulse.

Verification
REQ-034 Req0 only, len=1, tx=0xA5, model loops back -> cs_n[0] low CS_SETUP cycles before valid, o_rx=0xA5 with o_rx_valid=01, o_done=01, cs_n high after CS_HOLD.
REQ-035 i_req=11 from reset, len=2 each -> requester 0 served first, then 1; o_gnt 01 then 10; cs_n never both low; ≥1 cycle both high between.
REQ-036 Req1 i_len1=0 -> exactly 16 tx handshakes and 16 o_rx_valid[1] pulses, then one o_done[1].
REQ-037 Requester withholds i_tx_valid 20 cycles in FETCH -> o_spi_tx_valid stays 0, cs_n stays low, resumes on valid.
REQ-038 Reset pulsed during WAIT_RX -> next cycle all outputs at reset values, no o_done; subsequent req0 proceeds normally.
REQ-039 i_cfg0 changed mid-transaction -> o_spi_config unchanged until next grant.
